div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Shares the single multi-cycle divider IP (en/dividend/divisor in; ready/quotient/remainder/vld_out out) between up to N measurement requesters, e.g. the frequency, period and self-check paths of the cymometer.
- Arbitrates round-robin and sequences one division at a time.
- Traps divide-by-zero without touching the divider.
- Returns each result only to the requester that issued it.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DW, 59, dividend/divisor/quotient/remainder width.
- TIMEOUT_CYC, 1024, sys_clk cycles allowed between div_en and div_vld_out (used only when the optional feature is compiled in).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  per-requester request; held with its operands until req_ack.
- req_dividend  in  N_REQ*DW  packed operands; requester i uses slice [i*DW +: DW].
- req_divisor  in  N_REQ*DW  packed, same slicing as req_dividend.
- req_ack  out  N_REQ  one-cycle pulse: operands latched.
- rsp_valid  out  N_REQ  one-cycle pulse: result for requester i.
- rsp_quotient  out  DW  result, valid while rsp_valid is nonzero.
- rsp_remainder  out  DW  result, valid while rsp_valid is nonzero.
- rsp_err  out  1  qualifies rsp_valid: divide-by-zero or timeout.
- div_ready  in  1  divider can accept an operation.
- div_en  out  1  one-cycle start pulse to the divider.
- div_dividend  out  DW  divider operand.
- div_divisor  out  DW  divider operand.
- div_vld_out  in  1  divider result strobe.
- div_quotient  in  DW  divider result.
- div_remainder  in  DW  divider result.

Behaviour:
- One clock (sys_clk); asynchronous active-low reset sys_rst_n. All outputs are registered.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ack=0, rsp_valid=0, rsp_err=0, div_en=0.
  - rsp_quotient=0, rsp_remainder=0, div_dividend=0.
  - div_divisor=1 (never presents 0 to the IP).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - At that edge: latch the granted operands into div_dividend/div_divisor, register gnt_idx, pulse req_ack[gnt_idx].
  - Next state is ISSUE, or RESP if the latched divisor is 0.
  - No request: stay in IDLE.
- Double accept is impossible: req_ack is seen one cycle after latch, and the FSM has already left IDLE. The requester drops req_valid on seeing req_ack.
- ISSUE: wait for div_ready=1, then assert div_en for exactly one cycle and go to WAIT.
- div_dividend/div_divisor stay stable from latch until div_vld_out.
- WAIT: on div_vld_out=1, capture div_quotient/div_remainder into the rsp registers, rsp_err=0, go to RESP.
- div_vld_out outside WAIT is ignored (no capture).
- Divide-by-zero: no div_en is issued. Result is rsp_quotient=all ones, rsp_remainder=latched dividend, rsp_err=1.
- RESP:
  - Pulse rsp_valid[gnt_idx] for one cycle.
  - rr_ptr <= (gnt_idx+1) mod N_REQ (wrap-around).
  - Return to IDLE.
  - The rsp_* data registers hold until the next response.
- Throughput: back-to-back requests cost at most one IDLE cycle between operations.
- Minimum latency from request to response, with div_ready=1 and a divider latency of L cycles after en: L+4 cycles.
- Simultaneous events:
  - New req_valid arriving during ISSUE/WAIT/RESP waits for IDLE.
  - All N_REQ requesting continuously are served strictly in rotation; no starvation.
- Requester dropping req_valid before req_ack: illegal; no requirement.
- Reset mid-operation: FSM returns to IDLE, pending responses are lost, and no rsp_valid is produced. The divider's own reset is separate.

Optional Feature:
- Macro: DIV_SHARE_ARB_TIMEOUT_EN.
- Defined: a 16-bit watchdog counter clears on div_en and increments in WAIT. At TIMEOUT_CYC-1 without div_vld_out, the FSM goes to RESP with rsp_err=1, rsp_quotient=0, rsp_remainder=0. A late div_vld_out is then ignored in IDLE/ISSUE.
- Not defined: no counter; WAIT lasts until div_vld_out.

Decomposition:
- Shared package div_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - the DW default;
  - the all-ones quotient constant DIV_Q_SAT.
- Sub-module rr_pick: combinational round-robin priority picker (req vector, ptr) -> (any, idx), instantiated once.

Test Plan:
- Req0 with dividend=1000, divisor=7; divider latency 10 -> req_ack[0] one cycle later; div_en once; rsp_valid[0] with q=142, r=6, err=0, 14 cycles after request.
- Req0 and req1 asserted together, repeated, from rr_ptr=0 -> service order 0,1,0,1; rr_ptr wraps from N_REQ-1 to 0 with three requesters.
- Req2 with divisor=0 and dividend=5 -> no div_en; rsp_valid[2], err=1, q=all ones, r=5.
- div_ready held low for 20 cycles during ISSUE -> div_en issued only after div_ready rises; operands stable throughout.
- sys_rst_n pulsed low during WAIT -> all outputs reach reset values asynchronously; subsequent div_vld_out ignored; no rsp_valid.
- With DIV_SHARE_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, divider never responds -> rsp_err=1 and rsp_valid 16 cycles after div_en; next request is still served.

Source files
------------

// File: rtl/div_arb_pkg.sv
// ---------------------------------------------------------------------------
// div_arb_pkg
//   Shared definitions for the divider-sharing arbiter:
//     - arb_state_e : arbiter FSM states (IDLE / ISSUE / WAIT / RESP)
//     - DIV_DW_DEF  : default operand / result width
//     - DIV_MAX_DW  : widest operand width the saturation constant covers
//     - DIV_Q_SAT   : all-ones quotient returned on divide-by-zero
//                     (sliced down to the instance width by its users)
// ---------------------------------------------------------------------------
package div_arb_pkg;

    localparam int DIV_DW_DEF = 59;
    localparam int DIV_MAX_DW = 64;

    localparam logic [DIV_MAX_DW-1:0] DIV_Q_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage : div_arb_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Scans the request vector
//   starting at i_ptr and wrapping modulo N; the first set bit wins.
//
//   Ports
//     i_req  in  N   request vector
//     i_ptr  in  IW  highest-priority position (must be < N)
//     o_any  out 1   at least one request is set
//     o_idx  out IW  index of the winning request (0 when o_any = 0)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_any,
    output logic [IW-1:0] o_idx
);

    // Walk the offsets from the far end back toward i_ptr so the nearest
    // requester (smallest offset) is the last one written and therefore wins.
    always_comb begin
        int          j;
        logic [IW-1:0] w_pos;
        j     = 0;
        w_pos = '0;
        o_any = 1'b0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            w_pos = IW'(j);
            if (i_req[w_pos]) begin
                o_any = 1'b1;
                o_idx = w_pos;
            end
        end
    end

endmodule : rr_pick

// File: rtl/div_share_arbiter.sv
// ---------------------------------------------------------------------------
// div_share_arbiter
//   Shares one multi-cycle divider between N_REQ requesters. Requests are
//   granted round-robin, one division in flight at a time. A zero divisor is
//   answered locally (quotient all ones, remainder = dividend, error set)
//   without starting the divider. Each result is returned only to the
//   requester whose operands produced it.
//
//   Optional build macro: DIV_SHARE_ARB_TIMEOUT_EN
//     When defined, a 16-bit watchdog limits the time spent waiting for the
//     divider; on expiry the requester gets rsp_err=1 with zero data and a
//     late div_vld_out is ignored. When undefined, WAIT lasts until
//     div_vld_out and TIMEOUT_CYC only feeds the configuration check.
//
//   Handshakes
//     Request side: req_valid[i] is held with its operands until req_ack[i]
//     pulses; the operands are captured on the same edge that raises
//     req_ack, so the requester drops req_valid on seeing the ack. Response
//     side: rsp_valid[i] is a one-cycle pulse with rsp_quotient /
//     rsp_remainder / rsp_err valid in that cycle (data holds afterwards).
//     Divider side: div_en is a one-cycle pulse issued only while div_ready
//     is high; div_dividend / div_divisor hold from grant to result, and
//     div_vld_out is only accepted while waiting for a result.
//
//   Ports
//     sys_clk        in   1         system clock
//     sys_rst_n      in   1         asynchronous active-low reset
//     req_valid      in   N_REQ     per-requester request
//     req_dividend   in   N_REQ*DW  packed dividends, slice [i*DW +: DW]
//     req_divisor    in   N_REQ*DW  packed divisors,  slice [i*DW +: DW]
//     req_ack        out  N_REQ     one-cycle pulse: operands latched
//     rsp_valid      out  N_REQ     one-cycle pulse: result for requester i
//     rsp_quotient   out  DW        result quotient
//     rsp_remainder  out  DW        result remainder
//     rsp_err        out  1         divide-by-zero or timeout
//     div_ready      in   1         divider can accept an operation
//     div_en         out  1         one-cycle start pulse to the divider
//     div_dividend   out  DW        divider operand
//     div_divisor    out  DW        divider operand (never zero)
//     div_vld_out    in   1         divider result strobe
//     div_quotient   in   DW        divider result
//     div_remainder  in   DW        divider result
//     dbg_state      out  2         current FSM state (arb_state_e encoding)
// ---------------------------------------------------------------------------
module div_share_arbiter
    import div_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int DW          = DIV_DW_DEF,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,

    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*DW-1:0]   req_dividend,
    input  logic [N_REQ*DW-1:0]   req_divisor,
    output logic [N_REQ-1:0]      req_ack,

    output logic [N_REQ-1:0]      rsp_valid,
    output logic [DW-1:0]         rsp_quotient,
    output logic [DW-1:0]         rsp_remainder,
    output logic                  rsp_err,

    input  logic                  div_ready,
    output logic                  div_en,
    output logic [DW-1:0]         div_dividend,
    output logic [DW-1:0]         div_divisor,
    input  logic                  div_vld_out,
    input  logic [DW-1:0]         div_quotient,
    input  logic [DW-1:0]         div_remainder,

    output logic [1:0]            dbg_state
);

    localparam int IW = $clog2(N_REQ);

    // Elaboration-time configuration guards.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("div_share_arbiter: N_REQ must be in 2..8");
    end
    if (DW < 1 || DW > DIV_MAX_DW) begin : g_bad_dw
        $error("div_share_arbiter: DW must be in 1..DIV_MAX_DW");
    end
    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65536) begin : g_bad_timeout
        $error("div_share_arbiter: TIMEOUT_CYC must fit the 16-bit watchdog");
    end

    localparam logic [DW-1:0] Q_SAT = DIV_Q_SAT[DW-1:0];

    // ---------------- registers ----------------
    arb_state_e          r_state;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_gnt_idx;
    logic [N_REQ-1:0]    r_req_ack;
    logic [N_REQ-1:0]    r_rsp_valid;
    logic [DW-1:0]       r_rsp_quotient;
    logic [DW-1:0]       r_rsp_remainder;
    logic                r_rsp_err;
    logic                r_div_en;
    logic [DW-1:0]       r_div_dividend;
    logic [DW-1:0]       r_div_divisor;
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
    logic [15:0]         r_wd_cnt;
`endif

    // ---------------- grant selection ----------------
    logic                w_any;
    logic [IW-1:0]       w_gnt_idx;
    logic [DW-1:0]       w_sel_dividend;
    logic [DW-1:0]       w_sel_divisor;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_any (w_any),
        .o_idx (w_gnt_idx)
    );

    // Operand mux for the candidate winner.
    always_comb begin
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == IW'(i)) begin
                w_sel_dividend = req_dividend[i*DW +: DW];
                w_sel_divisor  = req_divisor[i*DW +: DW];
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= '0;
            r_gnt_idx       <= '0;
            r_req_ack       <= '0;
            r_rsp_valid     <= '0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_err       <= 1'b0;
            r_div_en        <= 1'b0;
            r_div_dividend  <= '0;
            r_div_divisor   <= DW'(1);
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
            r_wd_cnt        <= '0;
`endif
        end else begin
            // Pulses default low every cycle.
            r_req_ack   <= '0;
            r_rsp_valid <= '0;
            r_div_en    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt_idx      <= w_gnt_idx;
                        r_req_ack      <= N_REQ'(1) << w_gnt_idx;
                        r_div_dividend <= w_sel_dividend;
                        if (w_sel_divisor == '0) begin
                            // Answered locally. div_divisor keeps its previous
                            // (non-zero) value so the IP never sees a zero.
                            r_rsp_quotient  <= Q_SAT;
                            r_rsp_remainder <= w_sel_dividend;
                            r_rsp_err       <= 1'b1;
                            r_state         <= ST_RESP;
                        end else begin
                            r_div_divisor <= w_sel_divisor;
                            r_state       <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (div_ready) begin
                        r_div_en <= 1'b1;
                        r_state  <= ST_WAIT;
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
                        r_wd_cnt <= '0;
`endif
                    end
                end

                ST_WAIT: begin
                    if (div_vld_out) begin
                        r_rsp_quotient  <= div_quotient;
                        r_rsp_remainder <= div_remainder;
                        r_rsp_err       <= 1'b0;
                        r_state         <= ST_RESP;
                    end
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
                    // The counter reaches TIMEOUT_CYC-1 on this edge: give up,
                    // so rsp_valid appears TIMEOUT_CYC cycles after div_en.
                    else if (r_wd_cnt == 16'(TIMEOUT_CYC - 2)) begin
                        r_wd_cnt        <= r_wd_cnt + 16'd1;
                        r_rsp_quotient  <= '0;
                        r_rsp_remainder <= '0;
                        r_rsp_err       <= 1'b1;
                        r_state         <= ST_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    end
`endif
                end

                ST_RESP: begin
                    r_rsp_valid <= N_REQ'(1) << r_gnt_idx;
                    r_rr_ptr    <= (r_gnt_idx == IW'(N_REQ - 1)) ? '0
                                                                : r_gnt_idx + 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign req_ack       = r_req_ack;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_err       = r_rsp_err;
    assign div_en        = r_div_en;
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;
    assign dbg_state     = r_state;

endmodule : div_share_arbiter

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: a behavioural divider IP model, randomized
// requesters, and a reference model of grant order, response timing and
// result values derived from the arbiter's rules.
module tb_div_share_arbiter;

  localparam int N  = 3;
  localparam int DW = 59;
  localparam int TO = 16;

  // ---------------- clock / reset / DUT ----------------
  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_dividend;
  logic [N*DW-1:0]   req_divisor;
  logic [N-1:0]      req_ack;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_quotient;
  logic [DW-1:0]     rsp_remainder;
  logic              rsp_err;
  logic              div_ready;
  logic              div_en;
  logic [DW-1:0]     div_dividend;
  logic [DW-1:0]     div_divisor;
  logic              div_vld_out;
  logic [DW-1:0]     div_quotient;
  logic [DW-1:0]     div_remainder;
  logic [1:0]        dbg_state;

  div_share_arbiter #(
    .N_REQ       (N),
    .DW          (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .req_valid     (req_valid),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_ack       (req_ack),
    .rsp_valid     (rsp_valid),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_err       (rsp_err),
    .div_ready     (div_ready),
    .div_en        (div_en),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_vld_out   (div_vld_out),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .dbg_state     (dbg_state)
  );

  always #10 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // divider IP model
  int            lat     = 10;
  logic          dv_busy = 1'b0;
  int            dv_cnt  = 0;
  logic [DW-1:0] dv_a, dv_b;
  int            en_total = 0;

  // reference model
  int            m_ptr   = 0;
  logic          m_busy  = 1'b0;
  logic          m_issue = 1'b0;
  logic          m_zero  = 1'b0;
  int            m_idx   = 0;
  int            m_due   = -1;
  logic [DW-1:0] m_a, m_b;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_r[$];
  logic          exp_err;
  logic [DW-1:0] op_a[N];
  logic [DW-1:0] op_b[N];
  int            ack_cyc = 0;
  int            rsp_cyc = 0;
  int            dut_served[$];
  int            left[N];
  int            rsp_pulses = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h required 0x%0h", tag, cycle, got, exp);
    end
  endtask

  // First requester at or after ptr, wrapping modulo N.
  function automatic int rr_expect(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rnd_wide();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd_nz();
    logic [DW-1:0] v;
    case ($urandom_range(0, 2))
      0:       v = DW'($urandom_range(1, 100));
      1:       v = DW'($urandom());
      default: v = rnd_wide();
    endcase
    if (v == '0) v = DW'(1);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic raise(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    req_dividend[i*DW +: DW] = a;
    req_divisor[i*DW +: DW]  = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic reset_checks(input string pfx);
    check({pfx, "_req_ack"},       req_ack,       0);
    check({pfx, "_rsp_valid"},     rsp_valid,     0);
    check({pfx, "_rsp_err"},       rsp_err,       0);
    check({pfx, "_div_en"},        div_en,        0);
    check({pfx, "_rsp_quotient"},  rsp_quotient,  0);
    check({pfx, "_rsp_remainder"}, rsp_remainder, 0);
    check({pfx, "_div_dividend"},  div_dividend,  0);
    check({pfx, "_div_divisor"},   div_divisor,   1);
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs checked while held.
  task automatic do_reset(input bit keep_div);
    #5;
    sys_rst_n = 1'b0;
    #1;
    reset_checks("rst");
    req_valid = '0;
    m_busy = 1'b0; m_issue = 1'b0; m_zero = 1'b0; m_due = -1; m_ptr = 0;
    if (!keep_div) begin
      dv_busy = 1'b0;
      div_vld_out = 1'b0;
    end
    #3;
    sys_rst_n = 1'b1;
  endtask

  // One clock: sample after the edge, score against the model, then let the
  // divider model and requesters react.
  task automatic tick();
    logic [N-1:0] v_edge, exp_ack, exp_rsp;
    logic         rdy_edge, exp_en;
    int           g;
    v_edge   = req_valid;
    rdy_edge = div_ready;
    @(posedge sys_clk);
    #1;
    cycle++;

    exp_ack = '0; exp_rsp = '0; exp_en = 1'b0; g = -1;
    if (!m_busy && v_edge != '0) begin
      g = rr_expect(v_edge, m_ptr);
      exp_ack[g] = 1'b1;
    end
    if (m_busy && m_issue && rdy_edge) exp_en = 1'b1;
    if (m_busy && m_due == cycle) exp_rsp[m_idx] = 1'b1;

    check("req_ack", req_ack, exp_ack);
    check("div_en", div_en, exp_en);
    check("rsp_valid", rsp_valid, exp_rsp);

    for (int i = 0; i < N; i++) if (rsp_valid[i]) dut_served.push_back(i);
    if (rsp_valid != '0) rsp_pulses++;

    if (exp_rsp != '0) begin
      check("rsp_quotient", rsp_quotient, exp_q[0]);
      check("rsp_remainder", rsp_remainder, exp_r[0]);
      check("rsp_err", rsp_err, exp_err);
      m_ptr = (m_idx + 1) % N;
      m_busy = 1'b0;
      rsp_cyc = cycle;
    end

    if (exp_en) begin
      m_issue = 1'b0;
      m_due = cycle + lat + 2;
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
      if (lat >= TO - 1) begin
        m_due = cycle + TO;
        exp_q[0] = '0;
        exp_r[0] = '0;
        exp_err = 1'b1;
      end
`endif
    end

    if (g >= 0) begin
      m_busy = 1'b1; m_idx = g; m_a = op_a[g]; m_b = op_b[g];
      req_valid[g] = 1'b0;
      ack_cyc = cycle;
      exp_q.delete(); exp_r.delete();
      if (m_b == '0) begin
        m_zero = 1'b1; m_issue = 1'b0; m_due = cycle + 1;
        exp_q.push_back({DW{1'b1}}); exp_r.push_back(m_a); exp_err = 1'b1;
      end else begin
        m_zero = 1'b0; m_issue = 1'b1; m_due = -1;
        exp_q.push_back(m_a / m_b); exp_r.push_back(m_a % m_b); exp_err = 1'b0;
      end
    end

    // Operands held from grant until the divider answers.
    if (m_busy && !m_zero && (m_issue || cycle <= m_due - 2)) begin
      check("div_dividend_hold", div_dividend, m_a);
      check("div_divisor_hold", div_divisor, m_b);
    end

    // divider IP model: result L cycles after div_en rises
    if (div_vld_out) div_vld_out = 1'b0;
    if (dv_busy) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        dv_busy = 1'b0;
        div_vld_out = 1'b1;
        div_quotient  = (dv_b == '0) ? '1 : dv_a / dv_b;
        div_remainder = (dv_b == '0) ? '0 : dv_a % dv_b;
      end
    end
    if (div_en) begin
      en_total++;
      check("div_en_divisor_nz", div_divisor != '0, 1);
      dv_busy = 1'b1; dv_cnt = lat; dv_a = div_dividend; dv_b = div_divisor;
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((m_busy || req_valid != '0) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_done", (m_busy || req_valid != '0), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, en0, n, ord0[4], ord1[6];
    ord0 = '{0, 1, 0, 1};
    ord1 = '{2, 0, 1, 2, 0, 1};
    sys_rst_n = 1'b0;
    req_valid = '0; req_dividend = '0; req_divisor = '0;
    div_ready = 1'b1; div_vld_out = 1'b0; div_quotient = '0; div_remainder = '0;
    #15;
    reset_checks("por");
    #5;
    sys_rst_n = 1'b1;
    tick();

    // Single request, latency L+4.
    lat = 10; en0 = en_total;
    raise(0, DW'(1000), DW'(7)); t0 = cycle;
    drain(100);
    check("t1_ack_lat", ack_cyc - t0, 1);
    check("t1_rsp_lat", rsp_cyc - t0, 14);
    check("t1_quotient", rsp_quotient, 142);
    check("t1_remainder", rsp_remainder, 6);
    check("t1_err", rsp_err, 0);
    check("t1_en_count", en_total - en0, 1);

    // Two requesters alternating from rr_ptr=0.
    do_reset(1'b0);
    lat = 4; dut_served.delete();
    left = '{1, 1, 0};
    raise(0, rnd_wide(), rnd_nz()); raise(1, rnd_wide(), rnd_nz());
    n = 0;
    while (dut_served.size() < 4 && n < 400) begin
      tick(); n++;
      for (int i = 0; i < N; i++) if (!req_valid[i] && left[i] > 0) begin
        raise(i, rnd_wide(), rnd_nz()); left[i]--;
      end
    end
    drain(200);
    check("t2_count", dut_served.size(), 4);
    for (int k = 0; k < 4 && k < dut_served.size(); k++) check("t2_order", dut_served[k], ord0[k]);

    // All three continuously: rotation with wrap, starting at ptr=2.
    dut_served.delete();
    left = '{1, 1, 1};
    for (int i = 0; i < N; i++) raise(i, rnd_wide(), rnd_nz());
    n = 0;
    while (dut_served.size() < 6 && n < 400) begin
      tick(); n++;
      for (int i = 0; i < N; i++) if (!req_valid[i] && left[i] > 0) begin
        raise(i, rnd_wide(), rnd_nz()); left[i]--;
      end
    end
    drain(200);
    check("t3_count", dut_served.size(), 6);
    for (int k = 0; k < 6 && k < dut_served.size(); k++) check("t3_order", dut_served[k], ord1[k]);

    // Divide by zero.
    en0 = en_total;
    raise(2, DW'(5), DW'(0));
    drain(50);
    check("t4_en_count", en_total - en0, 0);
    check("t4_quotient", rsp_quotient, {DW{1'b1}});
    check("t4_remainder", rsp_remainder, 5);
    check("t4_err", rsp_err, 1);
    check("t4_idx", dut_served[$], 2);

    // div_ready low for 20 cycles while a request is in ISSUE.
    div_ready = 1'b0; en0 = en_total;
    raise(1, rnd_wide(), rnd_nz());
    for (int k = 0; k < 20; k++) tick();
    check("t5_no_en", en_total - en0, 0);
    div_ready = 1'b1;
    drain(100);
    check("t5_en_count", en_total - en0, 1);

    // Reset while waiting for the divider; its late strobe must be ignored.
    lat = 10; en0 = en_total;
    raise(0, rnd_wide(), rnd_nz());
    n = 0;
    while (en_total == en0 && n < 50) begin tick(); n++; end
    check("t6_en_seen", en_total - en0, 1);
    tick(); tick(); tick();
    do_reset(1'b1);
    rsp_pulses = 0;
    for (int k = 0; k < 20; k++) tick();
    check("t6_no_rsp", rsp_pulses, 0);

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      div_ready = ($urandom_range(0, 4) != 0);
      lat = $urandom_range(1, 12);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 5))
            0:       raise(i, rnd_wide(), DW'(0));
            1:       raise(i, DW'($urandom_range(0, 1000)), DW'($urandom_range(1, 50)));
            default: raise(i, rnd_wide(), rnd_nz());
          endcase
        end
      end
      tick();
    end
    div_ready = 1'b1;
    drain(500);

`ifdef DIV_SHARE_ARB_TIMEOUT_EN
    // Divider answers far too late: timeout, then normal service resumes.
    lat = 30;
    raise(1, DW'(100), DW'(3));
    drain(100);
    check("t7_err", rsp_err, 1);
    check("t7_quotient", rsp_quotient, 0);
    for (int k = 0; k < 20; k++) tick();
    lat = 5;
    raise(2, DW'(100), DW'(3));
    drain(100);
    check("t7_next_q", rsp_quotient, 33);
    check("t7_next_r", rsp_remainder, 1);
    check("t7_next_err", rsp_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_div_share_arbiter
